// File: rtl/gray_counter_ctrl.sv
// Run/pause/step/speed controller producing enable/clear strobes for a Gray counter.
// Latency: button edge to output change is 3 clk edges (2 sync + 1 FSM); outputs registered.
// Backpressure: none; events arriving in STEP/CLR are held one deep per button until handled.
module gray_counter_ctrl #(
    parameter int unsigned DISTANCE = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_speed,
    input  logic       btn_clear,
    output logic       enable,
    output logic       clear,
    output logic       running,
    output logic [1:0] speed
);

    localparam int unsigned PW = $clog2(DISTANCE);

    localparam int B_RUN   = 0;
    localparam int B_STEP  = 1;
    localparam int B_SPEED = 2;
    localparam int B_CLEAR = 3;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        CLR   = 2'd3
    } state_t;

    state_t          state;
    state_t          ret;
    logic [PW-1:0]   cnt;
    logic [PW-1:0]   tc;

    logic [3:0]      btn;
    logic [3:0]      s1;
    logic [3:0]      s2;
    logic [3:0]      p;
    logic [3:0]      pend;
    logic [3:0]      rise;
    logic [3:0]      ev;
    logic [3:0]      consume;

    assign btn  = {btn_clear, btn_speed, btn_step, btn_run};
    assign rise = s2 & ~p;
    // Speed is acted on immediately in every state, so it never needs a pending slot.
    assign ev   = rise | pend;

    function automatic logic [PW-1:0] term_count(input logic [1:0] sp);
        logic [31:0] t;
        t = DISTANCE >> sp;
        t = t - 32'd1;
        return t[PW-1:0];
    endfunction

    assign tc = term_count(speed);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            p  <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            p  <= s2;
        end
    end

    // Events the FSM acts on (or deliberately ignores) this cycle; losers of the
    // clear > run > step priority stay pending for a later cycle.
    always_comb begin
        consume = '0;
        case (state)
            PAUSE: begin
                if (ev[B_CLEAR])
                    consume[B_CLEAR] = 1'b1;
                else if (ev[B_RUN])
                    consume[B_RUN] = 1'b1;
                else if (ev[B_STEP])
                    consume[B_STEP] = 1'b1;
            end
            RUN: begin
                if (ev[B_CLEAR]) begin
                    consume[B_CLEAR] = 1'b1;
                end else begin
                    consume[B_RUN]  = 1'b1;
                    consume[B_STEP] = 1'b1;
                end
            end
            default: consume = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PAUSE;
            ret     <= PAUSE;
            cnt     <= '0;
            speed   <= 2'd0;
            enable  <= 1'b0;
            clear   <= 1'b0;
            running <= 1'b0;
            pend    <= '0;
        end else begin
            enable <= 1'b0;
            clear  <= 1'b0;
            pend   <= ev & ~consume & 4'b1011;

            if (rise[B_SPEED])
                speed <= speed + 2'd1;

            case (state)
                PAUSE: begin
                    cnt <= '0;
                    if (ev[B_CLEAR]) begin
                        state   <= CLR;
                        ret     <= PAUSE;
                        clear   <= 1'b1;
                        running <= 1'b0;
                    end else if (ev[B_RUN]) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (ev[B_STEP]) begin
                        state  <= STEP;
                        enable <= 1'b1;
                    end
                end
                RUN: begin
                    if (ev[B_CLEAR]) begin
                        state <= CLR;
                        ret   <= RUN;
                        clear <= 1'b1;
                        cnt   <= '0;
                    end else if (ev[B_RUN]) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        cnt     <= '0;
                    end else if (rise[B_SPEED]) begin
                        cnt <= '0;
                    end else if (cnt == tc) begin
                        cnt    <= '0;
                        enable <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STEP: begin
                    state <= PAUSE;
                    cnt   <= '0;
                end
                CLR: begin
                    state   <= ret;
                    cnt     <= '0;
                    running <= (ret == RUN);
                end
                default: begin
                    state   <= PAUSE;
                    cnt     <= '0;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Directed bench for gray_counter_ctrl with DISTANCE = 16 (T = 16/8/4/2).
module tb_gray_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_step;
    logic       btn_speed;
    logic       btn_clear;
    logic       enable;
    logic       clear;
    logic       running;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;

    gray_counter_ctrl #(.DISTANCE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_speed (btn_speed),
        .btn_clear (btn_clear),
        .enable    (enable),
        .clear     (clear),
        .running   (running),
        .speed     (speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (enable && clear) begin
                errors++;
                $display("FAIL exclusive: enable=%0b clear=%0b both high at %0t", enable, clear, $time);
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       run;
        logic       stp;
        logic       spd;
        logic       clr;
        logic       en;
        logic       cl;
        logic       rn;
        logic [1:0] sp;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_en(input int maxn, output int d);
        d = -1;
        for (int i = 1; i <= maxn; i++) begin
            tick();
            if (enable) begin
                d = i;
                break;
            end
        end
    endtask

    task automatic count_en(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (enable) c++;
        end
    endtask

    initial begin
        int d;
        int c;
        int sp;
        int tn;

        reset = 1'b1; btn_run = 1'b1; btn_step = 1'b1; btn_speed = 1'b1; btn_clear = 1'b1;

        //          rst   run   stp   spd   clr   en    cl    rn    sp
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

        // Reset, one step from PAUSE, clear from PAUSE.
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; btn_run = tbl[i].run; btn_step = tbl[i].stp;
            btn_speed = tbl[i].spd; btn_clear = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d.enable", i), int'(enable), int'(tbl[i].en));
            chk($sformatf("vec%0d.clear", i), int'(clear), int'(tbl[i].cl));
            chk($sformatf("vec%0d.running", i), int'(running), int'(tbl[i].rn));
            chk($sformatf("vec%0d.speed", i), int'(speed), int'(tbl[i].sp));
        end

        // Three steps, 10 cycles apart.
        for (int n = 0; n < 3; n++) begin
            btn_step = 1'b1;
            tick();
            btn_step = 1'b0;
            tick();
            chk("step_early", int'(enable), 0);
            tick();
            chk("step_enable", int'(enable), 1);
            tick();
            chk("step_width", int'(enable), 0);
            count_en(6, c);
            chk("step_extra", c, 0);
        end

        // Enter RUN and measure the first two enables.
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        tick();
        chk("run_early", int'(running), 0);
        tick();
        chk("run_entered", int'(running), 1);
        wait_en(40, d);
        chk("run_first_en", d, 16);
        tick();
        chk("run_en_width", int'(enable), 0);
        wait_en(40, d);
        chk("run_period", d, 15);

        // Step during RUN must not add an enable.
        btn_step = 1'b1;
        tick();
        btn_step = 1'b0;
        wait_en(40, d);
        chk("step_in_run", d, 15);

        // Speed cycling 1, 2, 3, 0.
        for (int i = 0; i < 4; i++) begin
            sp = (i + 1) % 4;
            tn = 16 >> sp;
            btn_speed = 1'b1;
            tick();
            btn_speed = 1'b0;
            tick();
            tick();
            chk($sformatf("speed_val%0d", sp), int'(speed), sp);
            wait_en(40, d);
            chk($sformatf("speed_first%0d", sp), d, tn);
            wait_en(40, d);
            chk($sformatf("speed_period%0d", sp), d, tn);
            wait_en(40, d);
            chk($sformatf("speed_period2_%0d", sp), d, tn);
        end

        // Clear from RUN.
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        tick();
        tick();
        chk("rclr_clear", int'(clear), 1);
        chk("rclr_enable", int'(enable), 0);
        chk("rclr_running", int'(running), 1);
        tick();
        chk("rclr_clear_width", int'(clear), 0);
        chk("rclr_resumed", int'(running), 1);
        wait_en(40, d);
        chk("rclr_next_en", d, 16);

        // Pause, then clear+run+step together.
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        tick();
        tick();
        chk("pause_running", int'(running), 0);
        count_en(20, c);
        chk("pause_no_en", c, 0);
        btn_clear = 1'b1; btn_run = 1'b1; btn_step = 1'b1;
        tick();
        btn_clear = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        tick();
        tick();
        chk("sim_clear", int'(clear), 1);
        chk("sim_clear_en", int'(enable), 0);
        chk("sim_clear_run", int'(running), 0);
        tick();
        chk("sim_back_clear", int'(clear), 0);
        chk("sim_back_pause", int'(running), 0);
        chk("sim_back_en", int'(enable), 0);
        tick();
        chk("sim_run", int'(running), 1);
        chk("sim_run_en", int'(enable), 0);
        wait_en(40, d);
        chk("sim_first_en", d, 16);

        // Reset mid-RUN at speed 3, one cycle before an expected enable.
        for (int n = 0; n < 3; n++) begin
            btn_speed = 1'b1;
            tick();
            btn_speed = 1'b0;
            tick();
            tick();
        end
        chk("rst_speed3", int'(speed), 3);
        wait_en(10, d);
        chk("rst_s3_first", d, 2);
        tick();
        chk("rst_s3_gap", int'(enable), 0);
        reset = 1'b1;
        tick();
        chk("rst_enable", int'(enable), 0);
        chk("rst_speed", int'(speed), 0);
        chk("rst_running", int'(running), 0);
        reset = 1'b0;
        tick();
        chk("rst_after_en", int'(enable), 0);
        chk("rst_after_clr", int'(clear), 0);
        chk("rst_after_run", int'(running), 0);
        count_en(10, c);
        chk("rst_no_en", c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
